// File: rtl/input_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_pkg
//  Description : Shared digit-select codes, digit limits and mode encoding
//                for the stopwatch control path.
//  Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    localparam logic [2:0] SEL_MIN_L    = 3'd3;
    localparam logic [2:0] SEL_MIN_R    = 3'd2;
    localparam logic [2:0] SEL_SEC_L    = 3'd1;
    localparam logic [2:0] SEL_SEC_R    = 3'd0;
    localparam logic [2:0] SEL_NONE     = 3'd5;

    localparam logic [3:0] DIGIT_MAX    = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        ADJUST = 1'b1
    } mode_t;

    // Select order walks from the most significant digit down, then back to none.
    function automatic logic [2:0] next_sel(input logic [2:0] sel);
        logic [2:0] nxt;
        case (sel)
            SEL_NONE:  nxt = SEL_MIN_L;
            SEL_MIN_L: nxt = SEL_MIN_R;
            SEL_MIN_R: nxt = SEL_SEC_L;
            SEL_SEC_L: nxt = SEL_SEC_R;
            default:   nxt = SEL_NONE;
        endcase
        return nxt;
    endfunction

    function automatic logic [3:0] clamp_digit(input logic [3:0] val, input logic [2:0] sel);
        logic [3:0] limit;
        limit = (sel == SEL_SEC_L) ? SEC_TENS_MAX : DIGIT_MAX;
        return (val > limit) ? limit : val;
    endfunction

endpackage
`default_nettype wire

// File: rtl/input_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : input_ctrl_if
//  Description : Raw board inputs and cleaned counter controls of input_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
interface input_ctrl_if;

    logic       btn_clr;
    logic       btn_pause;
    logic       btn_sel;
    logic       sw_adj;
    logic [3:0] sw_val;

    logic       clr;
    logic       paused;
    logic       adj;
    logic       btn_set_pause;
    logic [2:0] adj_sel;
    logic [3:0] adj_val;

    modport master (
        output btn_clr, btn_pause, btn_sel, sw_adj, sw_val,
        input  clr, paused, adj, btn_set_pause, adj_sel, adj_val
    );

    modport slave (
        input  btn_clr, btn_pause, btn_sel, sw_adj, sw_val,
        output clr, paused, adj, btn_set_pause, adj_sel, adj_val
    );

endinterface
`default_nettype wire

// File: rtl/input_ctrl_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : debounce
//  Description : Synchronizer plus hold-time debouncer with edge pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SYNC_STAGES     = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_raw,
    output logic      o_stable,
    output logic      o_rise,
    output logic      o_fall
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_stable;
    logic                   r_stable_d;
    logic                   w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync     <= '0;
            r_cnt      <= '0;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
        end else begin
            r_sync[0] <= i_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_stable_d <= r_stable;
            // Any return to the accepted level restarts the hold window.
            if (w_sync == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_stable <= w_sync;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_stable = r_stable;
    assign o_rise   = r_stable & ~r_stable_d;
    assign o_fall   = ~r_stable & r_stable_d;

endmodule
`default_nettype wire

// File: rtl/input_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : input_ctrl
//  Description : Debounced button/switch front end producing stopwatch
//                clear, pause, adjust, digit-select and set controls.
//  Revision    : 1.0 - initial release
// ============================================================================
module input_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SYNC_STAGES     = 2
) (
    input  wire logic   clk,
    input  wire logic   rst,
    input_ctrl_if.slave bus
);

    localparam int c_IDX_CLR   = 0;
    localparam int c_IDX_PAUSE = 1;
    localparam int c_IDX_SEL   = 2;
    localparam int c_IDX_ADJ   = 3;

    logic [3:0] w_raw;
    logic [3:0] w_stable;
    logic [3:0] w_rise;
    logic [3:0] w_fall;
    logic       w_unused;

    logic [3:0] r_val_sync [SYNC_STAGES];
    logic [3:0] w_val_sync;

    mode_t      r_state;
    logic       r_clr;
    logic       r_paused;
    logic       r_set;
    logic [2:0] r_adj_sel;
    logic [3:0] r_adj_val;

    assign w_raw = {bus.sw_adj, bus.btn_sel, bus.btn_pause, bus.btn_clr};

    for (genvar g = 0; g < 4; g++) begin : g_debounce
        debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES)
        ) u_deb (
            .clk      (clk),
            .rst      (rst),
            .i_raw    (w_raw[g]),
            .o_stable (w_stable[g]),
            .o_rise   (w_rise[g]),
            .o_fall   (w_fall[g])
        );
    end

    assign w_unused = &{1'b0, w_fall[2:0], w_stable};

    // Digit value switches are only synchronized; the clamp absorbs transients.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_val_sync[i] <= '0;
            end
        end else begin
            r_val_sync[0] <= bus.sw_val;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_val_sync[i] <= r_val_sync[i-1];
            end
        end
    end

    assign w_val_sync = r_val_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= RUN;
            r_clr     <= 1'b0;
            r_paused  <= 1'b0;
            r_set     <= 1'b0;
            r_adj_sel <= SEL_NONE;
            r_adj_val <= '0;
        end else begin
            r_clr     <= w_rise[c_IDX_CLR];
            r_set     <= 1'b0;
            r_adj_val <= clamp_digit(w_val_sync, r_adj_sel);
            // Mode changes take priority; pause/select presses in that cycle are dropped.
            case (r_state)
                RUN: begin
                    if (w_rise[c_IDX_ADJ]) begin
                        r_state   <= ADJUST;
                        r_paused  <= 1'b1;
                        r_adj_sel <= SEL_NONE;
                    end else if (w_rise[c_IDX_PAUSE]) begin
                        r_paused <= ~r_paused;
                    end
                end
                ADJUST: begin
                    if (w_fall[c_IDX_ADJ]) begin
                        r_state   <= RUN;
                        r_adj_sel <= SEL_NONE;
                    end else begin
                        if (w_rise[c_IDX_PAUSE] && (r_adj_sel != SEL_NONE)) begin
                            r_set <= 1'b1;
                        end
                        if (w_rise[c_IDX_SEL]) begin
                            r_adj_sel <= next_sel(r_adj_sel);
                        end
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

    assign bus.clr           = r_clr;
    assign bus.paused        = r_paused;
    assign bus.adj           = (r_state == ADJUST);
    assign bus.btn_set_pause = r_set;
    assign bus.adj_sel       = r_adj_sel;
    assign bus.adj_val       = r_adj_val;

endmodule
`default_nettype wire

// File: doc/input_ctrl.md
# input_ctrl

Front-end control stage for the stopwatch. It synchronizes and debounces the raw board buttons and switches, then turns them into the clean, single-cycle and level control signals the digit counter consumes: clear, pause, adjust mode, digit select, digit value and set strobe. It sits between the board I/O pins and the counter, in the same clock domain.

## Interface
- DEBOUNCE_CYCLES, 1_000_000: cycles a synchronized input must hold a new value before it is accepted (10 ms at 100 MHz).
- SYNC_STAGES, 2: flip-flop synchronizer depth on every raw input.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- btn_clr  in  1  raw clear button.
- btn_pause  in  1  raw pause/set button.
- btn_sel  in  1  raw digit-select button.
- sw_adj  in  1  raw adjust-mode switch.
- sw_val  in  4  raw digit-value switches.
- clr  out  1  one-cycle pulse: zero all digits.
- paused  out  1  level: counting halted.
- adj  out  1  level: adjust mode active.
- btn_set_pause  out  1  one-cycle pulse: load adj_val into digit adj_sel.
- adj_sel  out  3  selected digit: 3=min_l, 2=min_r, 1=sec_l, 0=sec_r, 5=none.
- adj_val  out  4  clamped digit value.

## Operation
- Every raw input passes through a SYNC_STAGES synchronizer. sw_val is synchronized only, not debounced.
- Debounce, per button and sw_adj:
  - The counter clears whenever the synchronized value equals the stable value.
  - Otherwise the counter increments.
  - At DEBOUNCE_CYCLES-1 the stable value takes the synchronized value and the counter clears.
- Press event: a stable 0→1 transition. Each press produces exactly one registered pulse.
- Mode FSM, states RUN and ADJUST:
  - RUN→ADJUST on stable sw_adj rising: paused←1, adj_sel←5.
  - ADJUST→RUN on stable sw_adj falling: adj_sel←5; paused is kept at 1.
  - adj=1 exactly while the state is ADJUST.
- RUN:
  - pause press toggles paused.
  - select press is ignored.
  - btn_set_pause is never asserted.
- ADJUST:
  - pause press → btn_set_pause pulse when adj_sel≠5; paused is unchanged.
  - select press cycles adj_sel 5→3→2→1→0→5.
- clr press → clr pulse in either state. paused, adj and adj_sel are unaffected.
- adj_val = min(sw_val_sync, limit), with limit=5 when adj_sel==1, else 9. It is registered and updated every cycle.
- Simultaneous events:
  - A mode change in the same cycle as a pause or select press: the mode change wins and the press is dropped.
  - Pause and select presses in the same cycle in ADJUST: btn_set_pause uses the pre-advance adj_sel, then adj_sel advances.
  - clr is independent of all other events and is never dropped.
- Reset values:
  - Outputs: clr=0, paused=0, adj=0, btn_set_pause=0, adj_sel=5, adj_val=0.
  - Internal state: state=RUN; all synchronizers, stable values and debounce counters are 0.
  - Reset mid-debounce discards the pending change.

## Timing
- Raw button held constant from edge T: the stable value updates at T+SYNC_STAGES+DEBOUNCE_CYCLES.
- Pulse or paused/adj update follows one cycle after the stable update.
- Glitches shorter than DEBOUNCE_CYCLES after synchronization produce no event.
- adj_val latency: SYNC_STAGES+1 cycles from sw_val change. It also recomputes one cycle after an adj_sel change.
- Pulse width is exactly 1 cycle. Minimum pulse spacing per button is 2×DEBOUNCE_CYCLES (press plus release).

## Structure
- stopwatch_pkg holds:
  - SEL_NONE=3'd5 and the digit index constants SEL_MIN_L..SEL_SEC_R.
  - DIGIT_MAX=9 and SEC_TENS_MAX=5.
  - mode_t enum {RUN, ADJUST}.
- One sub-module, debounce, instanced four times (clr, pause, sel, adj):
  - Synchronizer plus counter of width $clog2(DEBOUNCE_CYCLES).
  - Outputs: stable level and rise/fall pulses.

## Test plan
Benches run with DEBOUNCE_CYCLES=4.
- Bounce filtering: btn_pause toggles every 2 cycles for 20 cycles, then holds 1 → paused 0→1 exactly once; no change during bounce.
- RUN pause toggling: press/release pause twice → paused 1 then 0; btn_set_pause stays 0 throughout.
- Adjust entry and select cycle: sw_adj→1 → adj=1, paused=1, adj_sel=5; five select presses → adj_sel 3,2,1,0,5.
- Clamping: adj_sel=1 with sw_val=9 → adj_val=5; adj_sel=0 with sw_val=12 → adj_val=9.
- Set strobe: pause press in ADJUST → single-cycle btn_set_pause; paused remains 1. Pause press with adj_sel=5 → no pulse.
- Clear and reset: btn_clr press → exactly one clr pulse; other outputs unchanged.
- Reset mid-debounce: rst asserted at debounce count 3, then button released → no pulse; all outputs at reset values.
